vending_machine_param: RTL
==========================

Name: vending_machine_param

Overview:
Parametrised successor to the fixed 2-yuan drink vending FSM. Price and stock depth are parameters. Adds a 5-yuan coin, a cancel/refund path, and multi-coin change paid out over a valid/ready handshake. Also tracks stock, with sold-out and refill. Sits between the coin-acceptor front end and the dispenser/changer mechanics.

Parameters:
PRICE, 4, drink price in 5-jiao units (4 = 2 yuan); must be >= 1
CREDIT_W, 5, credit register width; 2^CREDIT_W-1 >= PRICE+9 required
STOCK_W, 4, stock counter width
STOCK_INIT, 10, stock after reset and after refill; must be <= 2^STOCK_W-1

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
coin  input  2  one-cycle coin pulse: 00 none, 01 5 jiao (1 unit), 10 1 yuan (2 units), 11 5 yuan (10 units)
cancel  input  1  one-cycle request to refund current credit
refill  input  1  one-cycle stock reload request
change_ready  input  1  changer accepts the presented coin
sell  output  1  one-cycle dispense pulse
coin_reject  output  1  one-cycle pulse; coin returned unaccepted
change_valid  output  1  a change coin is presented
change_coin  output  2  presented coin: 10 = 1 yuan, 01 = 5 jiao, 00 when change_valid=0
credit  output  CREDIT_W  current credit in units
stock  output  STOCK_W  drinks remaining
sold_out  output  1  stock == 0
busy  output  1  state is VEND or CHANGE

Behaviour:
- Reset: all sampled on the rising clk edge with rst=1. State=IDLE, credit=0, stock=STOCK_INIT, sell=0, coin_reject=0. change_valid=0, change_coin=00, busy=0, sold_out=(STOCK_INIT==0). Reset mid-operation discards credit, with no refund.
- States: IDLE (credit 0), COLLECT (0<credit<PRICE), VEND, CHANGE.
- Coin acceptance: a coin is accepted only in IDLE/COLLECT, with stock>0, cancel=0, and credit+value <= 2^CREDIT_W-1. Otherwise coin_reject=1 in the next cycle and credit is unchanged.
- Accept edge: sum = credit+value.
  - If sum >= PRICE: state<=VEND, credit<=sum-PRICE, stock<=stock-1, sell<=1 (registered, high exactly one cycle).
  - Otherwise: state<=COLLECT, credit<=sum.
- Latency: sell is visible in the cycle after the coin is sampled.
- VEND: lasts exactly one cycle. Next state is CHANGE if credit>0, else IDLE. Coins arriving in VEND are rejected.
- Cancel: in COLLECT, cancel moves the block to CHANGE with credit unchanged (full refund). Cancel wins over a same-cycle coin, which is rejected. Cancel in IDLE, VEND or CHANGE is ignored.
- CHANGE:
  - change_valid=1 and busy=1; both are combinational decodes of registered state and credit only.
  - change_coin=10 if credit>=2, else 01.
  - On change_valid&change_ready: credit decrements by 2 or 1 respectively. The state goes to IDLE when the new credit is 0.
  - change_coin and credit are held stable while change_ready=0.
  - Coins arriving in CHANGE are rejected.
- Stock: sold_out is a decode of stock==0. While sold_out, all coins are rejected. refill is honoured only in IDLE (stock<=STOCK_INIT) and is otherwise ignored. Stock never underflows, because VEND is unreachable with stock==0.
- Arithmetic: all credit math is unsigned at CREDIT_W+1 bits internally. No wrap is possible, given the acceptance rule.
- Next-state logic covers every state; an unreachable encoding recovers to IDLE with credit 0.

Optional Feature:
- Macro: VM_SALES_COUNT_EN.
- With the macro defined: adds output port sales_count [15:0]. It resets to 0, increments on every sell pulse, and wraps from 65535 to 0.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Defaults, after reset, coin 01 four times on consecutive cycles -> sell=1 for one cycle after the 4th coin; credit=0, stock=9, no change_valid.
- Coins 10, 01, 10 -> sell pulse; then CHANGE with change_coin=01. Hold change_ready=0 for 3 cycles -> change_valid stays 1, credit=1 stable. Then change_ready=1 -> credit=0, IDLE.
- Coin 11 from IDLE -> sell, credit=6. Then three handshakes of change_coin=10 -> credit 4, 2, 0, then IDLE.
- Coins 01, 10, then cancel -> refund 10 then 01. A coin 10 injected during CHANGE -> coin_reject=1 next cycle, credit unaffected.
- STOCK_INIT=1: buy once -> sold_out=1. Coin 10 -> coin_reject, credit stays 0. refill in IDLE -> stock=1, sold_out=0.
- rst=1 during CHANGE with credit=3 -> after the edge: state IDLE, credit=0, change_valid=0, stock=STOCK_INIT. With VM_SALES_COUNT_EN: sales_count=0.

Source files
------------

// File: rtl/vending_machine_param.sv
// vending_machine_param: parametrised drink vending controller.
// Accepts 5-jiao / 1-yuan / 5-yuan coins, dispenses when credit reaches PRICE,
// refunds on cancel, and pays change one coin per valid/ready handshake.
// Tracks stock with sold-out detection and refill while idle.
// Optional: define VM_SALES_COUNT_EN to add a 16-bit wrapping sales counter port.
module vending_machine_param #(
    parameter int unsigned PRICE      = 4,
    parameter int unsigned CREDIT_W   = 5,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                refill,
    input  logic                change_ready,
    output logic                sell,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out,
    output logic                busy
`ifdef VM_SALES_COUNT_EN
    ,
    output logic [15:0]         sales_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_X    = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] CREDIT_TWO = CREDIT_W'(2);
    localparam logic [STOCK_W-1:0]  STOCK_RST  = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  STOCK_ONE  = STOCK_W'(1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                sell_q, sell_d;
    logic                reject_q, reject_d;

    logic [CREDIT_W:0]   coin_value;
    logic [CREDIT_W:0]   sum;
    logic                can_accept;
    logic [STOCK_W-1:0]  stock_base;

    // Decode the coin pulse into credit units.
    always_comb begin
        coin_value = '0;
        case (coin)
            2'b01:   coin_value = (CREDIT_W + 1)'(1);
            2'b10:   coin_value = (CREDIT_W + 1)'(2);
            2'b11:   coin_value = (CREDIT_W + 1)'(10);
            default: coin_value = '0;
        endcase
    end

    assign sum        = {1'b0, credit_q} + coin_value;
    assign can_accept = ((state_q == IDLE) || (state_q == COLLECT)) &&
                        (stock_q != '0) && !cancel && (sum <= CREDIT_MAX);
    // A refill and a sale on the same idle edge both take effect: reload, then decrement.
    assign stock_base = ((state_q == IDLE) && refill) ? STOCK_RST : stock_q;

    // Next-state, credit, stock and pulse computation.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stock_d  = stock_q;
        sell_d   = 1'b0;
        reject_d = (coin != 2'b00) && !can_accept;
        case (state_q)
            IDLE, COLLECT: begin
                stock_d = stock_base;
                if ((state_q == COLLECT) && cancel) begin
                    state_d = CHANGE;
                end else if ((coin != 2'b00) && can_accept) begin
                    if (sum >= PRICE_X) begin
                        state_d  = VEND;
                        credit_d = CREDIT_W'(sum - PRICE_X);
                        stock_d  = stock_base - STOCK_ONE;
                        sell_d   = 1'b1;
                    end else begin
                        state_d  = COLLECT;
                        credit_d = CREDIT_W'(sum);
                    end
                end
            end
            VEND: begin
                state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (change_ready) begin
                    credit_d = credit_q - ((credit_q >= CREDIT_TWO) ? CREDIT_TWO : CREDIT_ONE);
                    if (credit_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State, credit, stock and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            stock_q  <= STOCK_RST;
            sell_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stock_q  <= stock_d;
            sell_q   <= sell_d;
            reject_q <= reject_d;
        end
    end

`ifdef VM_SALES_COUNT_EN
    logic [15:0] sales_q;

    // Count dispenses; the count moves on the same edge that raises sell.
    always_ff @(posedge clk) begin
        if (rst) begin
            sales_q <= '0;
        end else if (sell_d) begin
            sales_q <= sales_q + 16'd1;
        end
    end

    assign sales_count = sales_q;
`endif

    assign sell         = sell_q;
    assign coin_reject  = reject_q;
    assign change_valid = (state_q == CHANGE);
    assign change_coin  = (state_q != CHANGE) ? 2'b00 :
                          (credit_q >= CREDIT_TWO) ? 2'b10 : 2'b01;
    assign credit       = credit_q;
    assign stock        = stock_q;
    assign sold_out     = (stock_q == '0);
    assign busy         = (state_q == VEND) || (state_q == CHANGE);

endmodule
